// File: rtl/formula_nsqrt_pipe_aware_fsm_if.sv
// Bundle of the argument/result handshake and the external isqrt stream.
// The FSM block uses the slave modport; a wrapper or bench uses the master side.
interface formula_nsqrt_pipe_aware_fsm_if #(
  parameter int unsigned NArgs = 3,
  parameter int unsigned ArgW  = 32,
  parameter int unsigned ResW  = 32
);
  logic                    arg_vld;
  logic                    arg_rdy;
  logic                    op_max;
  logic [NArgs*ArgW-1:0]   args;
  logic                    res_vld;
  logic [ResW-1:0]         res;
  logic                    isqrt_x_vld;
  logic [ArgW-1:0]         isqrt_x;
  logic                    isqrt_y_vld;
  logic [ArgW/2-1:0]       isqrt_y;

  modport master (
    output arg_vld, op_max, args, isqrt_y_vld, isqrt_y,
    input  arg_rdy, res_vld, res, isqrt_x_vld, isqrt_x
  );

  modport slave (
    input  arg_vld, op_max, args, isqrt_y_vld, isqrt_y,
    output arg_rdy, res_vld, res, isqrt_x_vld, isqrt_x
  );
endinterface

// File: rtl/formula_nsqrt_pipe_aware_fsm.sv
// Streams NArgs operands into an external pipelined isqrt and reduces the returned roots
// to their sum or maximum. Holds only the FSM, operand registers and reduction datapath.
module formula_nsqrt_pipe_aware_fsm #(
  parameter int unsigned NArgs    = 3,
  parameter int unsigned ArgW     = 32,
  parameter int unsigned ResW     = 32,
  parameter int unsigned IsqrtLat = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  formula_nsqrt_pipe_aware_fsm_if.slave bus_io
);
  localparam int unsigned CntW = $clog2(NArgs + 1);
  localparam int unsigned DrnW = (IsqrtLat > 0) ? $clog2(IsqrtLat + 1) : 1;

  typedef enum logic [1:0] {StDrain, StIdle, StIssue, StWait} state_e;

  state_e            state_q, state_d;
  logic [DrnW-1:0]   drain_q, drain_d;
  logic [CntW-1:0]   iss_q, iss_d, ret_q, ret_d;
  logic [ResW-1:0]   acc_q, acc_d, res_q, res_d;
  logic [ResW-1:0]   y_ext;
  logic              res_vld_q, res_vld_d;
  logic              op_max_q, op_max_d;
  logic [ArgW-1:0]   args_q [NArgs];
  logic [ArgW-1:0]   args_d [NArgs];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StDrain;
      drain_q   <= DrnW'(IsqrtLat);
      iss_q     <= '0;
      ret_q     <= '0;
      acc_q     <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
      op_max_q  <= 1'b0;
      for (int i = 0; i < int'(NArgs); i++) args_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      iss_q     <= iss_d;
      ret_q     <= ret_d;
      acc_q     <= acc_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
      op_max_q  <= op_max_d;
      for (int i = 0; i < int'(NArgs); i++) args_q[i] <= args_d[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    iss_d     = iss_q;
    ret_d     = ret_q;
    acc_d     = acc_q;
    res_d     = res_q;
    res_vld_d = 1'b0;
    op_max_d  = op_max_q;
    args_d    = args_q;
    y_ext     = ResW'(bus_io.isqrt_y);

    unique case (state_q)
      // Results still in flight from an interrupted operation are dropped here.
      StDrain: begin
        if (drain_q <= DrnW'(1)) begin
          drain_d = '0;
          state_d = StIdle;
        end else begin
          drain_d = drain_q - DrnW'(1);
        end
      end
      StIdle: begin
        if (bus_io.arg_vld) begin
          for (int i = 0; i < int'(NArgs); i++) args_d[i] = bus_io.args[i*ArgW +: ArgW];
          op_max_d = bus_io.op_max;
          acc_d    = '0;
          iss_d    = '0;
          ret_d    = '0;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        iss_d = iss_q + CntW'(1);
        if (iss_q == CntW'(NArgs - 1)) state_d = StWait;
      end
      StWait: begin
        if (ret_q == CntW'(NArgs)) begin
          res_d     = acc_q;
          res_vld_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StDrain;
    endcase

    // Returns may overlap issues when the isqrt latency is shorter than NArgs.
    if ((state_q == StIssue || state_q == StWait) && bus_io.isqrt_y_vld) begin
      ret_d = ret_q + CntW'(1);
      if (op_max_q) acc_d = (y_ext > acc_q) ? y_ext : acc_q;
      else          acc_d = acc_q + y_ext;
    end
  end

  always_comb begin
    bus_io.arg_rdy     = (state_q == StIdle);
    bus_io.isqrt_x_vld = (state_q == StIssue);
    bus_io.isqrt_x     = '0;
    if (state_q == StIssue) begin
      for (int i = 0; i < int'(NArgs); i++) begin
        if (iss_q == CntW'(i)) bus_io.isqrt_x = args_q[i];
      end
    end
    bus_io.res_vld = res_vld_q;
    bus_io.res     = res_q;
  end
endmodule

// File: tb/tb_formula_nsqrt_pipe_aware_fsm.sv
// Bench: two DUT builds (3 args / latency 16 and 8 args / latency 2) beside behavioural
// isqrt pipes, checked every cycle against a transaction-level model plus literal results.
module tb_formula_nsqrt_pipe_aware_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int na  [2] = '{3, 8};
  int lat [2] = '{16, 2};

  logic        vld_in [2];
  logic        op_in  [2];
  logic [31:0] a_in   [2][8];
  logic        rdy [2], rvld [2], xvld [2];
  logic [31:0] res_o [2], x_o [2];
  logic [16:0] pa [16] = '{default: '0};
  logic [16:0] pb [2]  = '{default: '0};

  formula_nsqrt_pipe_aware_fsm_if #(.NArgs(3), .ArgW(32), .ResW(32)) if_a ();
  formula_nsqrt_pipe_aware_fsm_if #(.NArgs(8), .ArgW(32), .ResW(32)) if_b ();

  formula_nsqrt_pipe_aware_fsm #(.NArgs(3), .ArgW(32), .ResW(32), .IsqrtLat(16)) u_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(if_a)
  );
  formula_nsqrt_pipe_aware_fsm #(.NArgs(8), .ArgW(32), .ResW(32), .IsqrtLat(2)) u_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(if_b)
  );

  assign if_a.arg_vld = vld_in[0];
  assign if_a.op_max  = op_in[0];
  assign if_a.args    = {a_in[0][2], a_in[0][1], a_in[0][0]};
  assign if_b.arg_vld = vld_in[1];
  assign if_b.op_max  = op_in[1];
  assign if_b.args    = {a_in[1][7], a_in[1][6], a_in[1][5], a_in[1][4],
                         a_in[1][3], a_in[1][2], a_in[1][1], a_in[1][0]};
  assign if_a.isqrt_y_vld = pa[15][16];
  assign if_a.isqrt_y     = pa[15][15:0];
  assign if_b.isqrt_y_vld = pb[1][16];
  assign if_b.isqrt_y     = pb[1][15:0];
  assign rdy[0]  = if_a.arg_rdy;
  assign rdy[1]  = if_b.arg_rdy;
  assign rvld[0] = if_a.res_vld;
  assign rvld[1] = if_b.res_vld;
  assign res_o[0] = if_a.res;
  assign res_o[1] = if_b.res;
  assign xvld[0] = if_a.isqrt_x_vld;
  assign xvld[1] = if_b.isqrt_x_vld;
  assign x_o[0]  = if_a.isqrt_x;
  assign x_o[1]  = if_b.isqrt_x;

  function automatic logic [15:0] isq(input logic [31:0] x);
    longint r = 0;
    longint t;
    for (int b = 15; b >= 0; b--) begin
      t = r + (longint'(1) << b);
      if (t * t <= longint'(x)) r = t;
    end
    return r[15:0];
  endfunction

  // External isqrt pipes; deliberately not reset so stale results survive a reset.
  always @(posedge clk) begin
    pa[0] <= {if_a.isqrt_x_vld, isq(if_a.isqrt_x)};
    for (int i = 1; i < 16; i++) pa[i] <= pa[i-1];
    pb[0] <= {if_b.isqrt_x_vld, isq(if_b.isqrt_x)};
    pb[1] <= pb[0];
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction model: one outstanding op, timing from accept / reset edges.
  longint m_args [2][8];
  longint exp_res [2], last_res [2];
  int     ready_at [2] = '{1 << 30, 1 << 30};
  int     done_at [2], iss_at [2];
  bit     pending [2];

  initial forever begin
    longint r, y;
    @(posedge clk);
    cyc++;
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        ready_at[u] = cyc + lat[u];
        pending[u]  = 1'b0;
        last_res[u] = 0;
      end else begin
        if (pending[u] && cyc == done_at[u]) last_res[u] = exp_res[u];
        if (vld_in[u] && cyc - 1 >= ready_at[u]) begin
          r = 0;
          for (int i = 0; i < na[u]; i++) begin
            m_args[u][i] = longint'(a_in[u][i]);
            y = longint'(isq(a_in[u][i]));
            if (op_in[u]) r = (y > r) ? y : r;
            else          r = r + y;
          end
          exp_res[u]  = r;
          pending[u]  = 1'b1;
          iss_at[u]   = cyc;
          done_at[u]  = cyc + na[u] + lat[u] + 1;
          ready_at[u] = done_at[u];
        end
      end
    end
  end

  initial forever begin
    bit     in_iss;
    longint ex;
    @(negedge clk);
    if (cyc >= 1) begin
      for (int u = 0; u < 2; u++) begin
        in_iss = pending[u] && cyc >= iss_at[u] && cyc < iss_at[u] + na[u];
        ex = in_iss ? m_args[u][cyc - iss_at[u]] : 0;
        chk($sformatf("u%0d arg_rdy", u), longint'(rdy[u]), longint'(cyc >= ready_at[u]));
        chk($sformatf("u%0d res_vld", u), longint'(rvld[u]),
            longint'(pending[u] && cyc == done_at[u]));
        chk($sformatf("u%0d res", u), longint'(res_o[u]), last_res[u]);
        chk($sformatf("u%0d isqrt_x_vld", u), longint'(xvld[u]), longint'(in_iss));
        chk($sformatf("u%0d isqrt_x", u), longint'(x_o[u]), ex);
      end
    end
  end

  task automatic wait_rdy(input int u);
    int n = 0;
    while (rdy[u] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_cmp++;
      n_fail++;
      $display("FAIL u%0d wait arg_rdy: still low after %0d cycles, required 1", u, n);
    end
  endtask

  task automatic send(input int u, input bit op, input logic [31:0] a [8]);
    a_in[u]   = a;
    op_in[u]  = op;
    vld_in[u] = 1'b1;
    @(negedge clk);
    vld_in[u] = 1'b0;
  endtask

  task automatic wait_res(input int u, input longint exp, input string nm, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rvld[u] !== 1'b1 && n < 300);
    if (rvld[u] === 1'b1) chk(nm, longint'(res_o[u]), exp);
    else begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: no res_vld within %0d cycles, required res %0d", nm, n, exp);
    end
  endtask

  initial begin
    logic [31:0] v [8];
    int n, nres;
    vld_in = '{1'b0, 1'b0};
    op_in  = '{1'b0, 1'b0};
    for (int u = 0; u < 2; u++) for (int i = 0; i < 8; i++) a_in[u][i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    wait_rdy(0);
    v = '{1, 4, 9, 0, 0, 0, 0, 0};
    send(0, 1'b0, v);
    chk("u0 first isqrt_x", longint'(x_o[0]), 1);
    wait_res(0, 6, "u0 sum {1,4,9}", n);
    chk("u0 accept-to-res cycles", n, 20);

    v = '{16, 81, 4, 0, 0, 0, 0, 0};
    send(0, 1'b1, v);
    wait_res(0, 9, "u0 max {16,81,4}", n);
    v = '{0, 0, 0, 0, 0, 0, 0, 0};
    send(0, 1'b0, v);
    wait_res(0, 0, "u0 sum {0,0,0}", n);
    v = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0};
    send(0, 1'b0, v);
    wait_res(0, 196605, "u0 sum all-ones", n);

    // arg_vld held high with args changing every cycle.
    wait_rdy(0);
    nres = 0;
    vld_in[0] = 1'b1;
    for (int j = 0; j < 50; j++) begin
      if (j == 0) begin
        a_in[0][0] = 1;
        a_in[0][1] = 4;
        a_in[0][2] = 9;
        op_in[0]   = 1'b0;
      end else begin
        a_in[0][0] = 32'(j);
        a_in[0][1] = 81;
        a_in[0][2] = 32'(2 * j);
        op_in[0]   = 1'b1;
      end
      @(negedge clk);
      if (rvld[0] === 1'b1) begin
        if (nres < 2)
          chk($sformatf("u0 stream result %0d", nres), longint'(res_o[0]), (nres == 0) ? 6 : 9);
        nres++;
      end
    end
    vld_in[0] = 1'b0;
    wait_res(0, 9, "u0 stream result 2", n);
    chk("u0 stream results during hold", nres, 2);

    // Reset two cycles after accept.
    wait_rdy(0);
    v = '{1, 4, 9, 0, 0, 0, 0, 0};
    send(0, 1'b0, v);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("u0 arg_rdy after reset", longint'(rdy[0]), 0);
    n = 0;
    while (rdy[0] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("u0 drain cycles", n, 16);
    v = '{25, 36, 49, 0, 0, 0, 0, 0};
    send(0, 1'b0, v);
    wait_res(0, 18, "u0 sum {25,36,49} after reset", n);

    // Eight args with returns overlapping issues.
    wait_rdy(1);
    v = '{1, 4, 9, 16, 25, 36, 49, 64};
    send(1, 1'b0, v);
    wait_res(1, 36, "u1 sum k^2 k=1..8", n);
    chk("u1 accept-to-res cycles", n, 11);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end
endmodule
